// File: rtl/coherence_bus_ctrl.sv
// Snooping-bus MSI coherence controller for NCPU cores: round-robin grant, snoop broadcast,
// cache-to-cache forwarding with concurrent memory update, memory fill, writeback and upgrade.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NCPU     = 2,
    parameter int BLKWORDS = 2,
    parameter int SNPLAT   = 2,
    localparam int WSW     = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1,
    localparam int IDW     = $clog2(NCPU)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NCPU-1:0]       req,
    input  logic [NCPU-1:0][1:0]  reqtype,
    input  logic [NCPU-1:0][31:0] daddr,
    input  logic [NCPU-1:0][31:0] dstore,
    input  logic [NCPU-1:0]       hitm,
    output logic [NCPU-1:0]       dwait,
    output logic [NCPU-1:0][31:0] dload,
    output logic [WSW-1:0]        wordsel,
    output logic [NCPU-1:0]       ccwait,
    output logic [NCPU-1:0]       ccinv,
    output logic [31:0]           ccsnoopaddr,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    output logic                  ramREN,
    output logic                  ramWEN,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);
    localparam int OFFW = $clog2(BLKWORDS) + 2;
    localparam int SCW  = $clog2(SNPLAT + 1);

    typedef enum logic [2:0] {IDLE, SNOOP, FILL, FWD, WB, INV, DONE} state_t;
    typedef enum logic [1:0] {T_RD, T_RDX, T_UPG, T_WB} reqtype_t;

    state_t        state;
    reqtype_t      ttype;
    logic [IDW-1:0] id, owner, last, winner, hit_idx;
    logic [31:0]   base, word_addr;
    logic [WSW-1:0] k;
    logic [SCW-1:0] scnt;
    logic          first, any_req, any_hit, last_word, acc;
    logic [NCPU-1:0] others;
    logic          unused_addr_lo;

    // Round-robin: first requester strictly after the previous winner.
    always_comb begin
        winner  = last;
        any_req = 1'b0;
        for (int i = 1; i <= NCPU; i++) begin
            if (!any_req && req[(int'(last) + i) % NCPU]) begin
                any_req = 1'b1;
                winner  = IDW'((int'(last) + i) % NCPU);
            end
        end
    end

    // Descending scan so the lowest-numbered M holder supplies when several claim it.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int j = NCPU - 1; j >= 0; j--) begin
            if (hitm[j] && IDW'(j) != id) begin
                any_hit = 1'b1;
                hit_idx = IDW'(j);
            end
        end
    end

    always_comb begin
        unused_addr_lo = 1'b0;
        for (int i = 0; i < NCPU; i++) unused_addr_lo = unused_addr_lo ^ (^daddr[i][OFFW-1:0]);
    end

    assign last_word = (k == WSW'(BLKWORDS - 1));
    assign acc       = (ramstate == ACCESS);
    assign word_addr = base + 32'({k, 2'b00});
    assign others    = ~(NCPU'(1) << id);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            ttype <= T_RD;
            last  <= IDW'(NCPU - 1);
            id    <= '0;
            owner <= '0;
            base  <= '0;
            k     <= '0;
            scnt  <= '0;
            first <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    id    <= winner;
                    last  <= winner;
                    ttype <= reqtype_t'(reqtype[winner]);
                    base  <= {daddr[winner][31:OFFW], {OFFW{1'b0}}};
                    k     <= '0;
                    scnt  <= '0;
                    state <= (reqtype_t'(reqtype[winner]) == T_WB) ? WB : SNOOP;
                end
                SNOOP: if (scnt == SCW'(SNPLAT - 1)) begin
                    scnt  <= '0;
                    owner <= hit_idx;
                    first <= 1'b1;
                    if (ttype == T_UPG)  state <= INV;
                    else if (any_hit)    state <= FWD;
                    else                 state <= FILL;
                end else begin
                    scnt <= scnt + SCW'(1);
                end
                FILL, FWD, WB: begin
                    first <= 1'b0;
                    if (acc) begin
                        if (last_word) begin
                            k     <= '0;
                            state <= DONE;
                        end else begin
                            k <= k + WSW'(1);
                        end
                    end
                end
                INV:     state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        dwait       = '1;
        dload       = '0;
        wordsel     = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramaddr     = '0;
        ramstore    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        case (state)
            SNOOP: begin
                ccwait      = others;
                ccsnoopaddr = base;
            end
            INV: begin
                ccwait      = others;
                ccsnoopaddr = base;
                ccinv       = others;
                dwait[id]   = 1'b0;
            end
            FILL: begin
                ccwait      = others;
                ccsnoopaddr = base;
                ramREN      = 1'b1;
                ramaddr     = word_addr;
                dload[id]   = ramload;
                wordsel     = k;
                if (first && ttype == T_RDX) ccinv = others;
                if (acc) dwait[id] = 1'b0;
            end
            FWD: begin
                ccwait      = others;
                ccsnoopaddr = base;
                ramWEN      = 1'b1;
                ramaddr     = word_addr;
                ramstore    = dstore[owner];
                dload[id]   = dstore[owner];
                wordsel     = k;
                if (acc) begin
                    dwait[id]    = 1'b0;
                    dwait[owner] = 1'b0;
                    if (last_word && ttype == T_RDX) ccinv[owner] = 1'b1;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = word_addr;
                ramstore = dstore[id];
                wordsel  = k;
                if (acc) dwait[id] = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Randomised bench for coherence_bus_ctrl: a transaction-level model predicts grant order and
// the cycle-by-cycle bus behaviour of each transaction from the protocol rules.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    localparam int NCPU = 4, BLKWORDS = 4, SNPLAT = 2, WSW = 2;
    localparam logic [31:0] BMASK = 32'(BLKWORDS * 4 - 1);
    localparam int RD = 0, RDX = 1, UPG = 2, WBT = 3;

    logic CLK = 1'b0, nRST;
    logic [NCPU-1:0]       req, hitm, dwait, ccwait, ccinv;
    logic [NCPU-1:0][1:0]  reqtype;
    logic [NCPU-1:0][31:0] daddr, dstore, dload;
    logic [WSW-1:0]        wordsel;
    logic [31:0]           ccsnoopaddr, ramaddr, ramstore, ramload;
    logic                  ramREN, ramWEN;
    ramstate_t             ramstate;

    int n_vec = 0, n_err = 0;
    int last_m;
    logic [NCPU-1:0] pend;
    int          ptype [NCPU];
    logic [31:0] paddr [NCPU];

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.NCPU(NCPU), .BLKWORDS(BLKWORDS), .SNPLAT(SNPLAT)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .reqtype(reqtype), .daddr(daddr), .dstore(dstore),
        .hitm(hitm), .dwait(dwait), .dload(dload), .wordsel(wordsel), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ramstate_t rand_st();
        return ramstate_t'(2'($urandom));
    endfunction

    // Drive one cycle of stimulus shortly after the rising edge; the granted core's address and
    // type are scrambled after the grant since they must not be resampled.
    task automatic drive_cycle(input ramstate_t st, input int scr);
        @(posedge CLK);
        #1;
        for (int c = 0; c < NCPU; c++) dstore[c] = $urandom;
        ramload  = $urandom;
        ramstate = st;
        hitm     = NCPU'($urandom);
        req      = pend;
        if (scr >= 0) begin
            daddr[scr]   = $urandom;
            reqtype[scr] = 2'($urandom);
        end
    endtask

    task automatic observe(input string tag, input logic [NCPU-1:0] e_dwait, input logic [NCPU-1:0] e_ccwait,
                           input logic [NCPU-1:0] e_ccinv, input logic e_ren, input logic e_wen,
                           input logic [31:0] e_addr, input logic [31:0] e_store, input logic [31:0] e_snp,
                           input int e_ws, input logic [NCPU-1:0][31:0] e_dload);
        @(negedge CLK);
        check({tag, ".dwait"},   128'(dwait),       128'(e_dwait));
        check({tag, ".ccwait"},  128'(ccwait),      128'(e_ccwait));
        check({tag, ".ccinv"},   128'(ccinv),       128'(e_ccinv));
        check({tag, ".ramREN"},  128'(ramREN),      128'(e_ren));
        check({tag, ".ramWEN"},  128'(ramWEN),      128'(e_wen));
        check({tag, ".ramaddr"}, 128'(ramaddr),     128'(e_addr));
        check({tag, ".ramstore"},128'(ramstore),    128'(e_store));
        check({tag, ".snpaddr"}, 128'(ccsnoopaddr), 128'(e_snp));
        check({tag, ".wordsel"}, 128'(wordsel),     128'(e_ws));
        check({tag, ".dload"},   128'(dload),       128'(e_dload));
    endtask

    task automatic observe_idle(input string tag);
        observe(tag, '1, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, '0);
    endtask

    task automatic post_req(input int c, input int t, input logic [31:0] a);
        pend[c]    = 1'b1;
        ptype[c]   = t;
        paddr[c]   = a;
        daddr[c]   = a;
        reqtype[c] = 2'(t);
    endtask

    // Serve the next pending request as the model arbitrates it; rst_word>=0 pulses nRST
    // on the first cycle of that data word.
    task automatic run_next(input logic [NCPU-1:0] hmask, input bit drop, input int rst_word);
        int w, t, o, lat;
        bit acc;
        logic [31:0] b, a;
        logic [NCPU-1:0] oth, dw, ci;
        logic [NCPU-1:0][31:0] dl;
        w = -1;
        for (int i = 1; i <= NCPU; i++)
            if (w < 0 && pend[(last_m + i) % NCPU]) w = (last_m + i) % NCPU;
        if (w < 0) return;
        last_m = w;
        t   = ptype[w];
        b   = paddr[w] & ~BMASK;
        oth = ~(NCPU'(1) << w);

        drive_cycle(rand_st(), -1);
        observe_idle("grant");

        if (t != WBT) begin
            for (int s = 0; s < SNPLAT; s++) begin
                drive_cycle(rand_st(), w);
                if (s == SNPLAT - 1) hitm = hmask;
                observe("snoop", '1, oth, '0, 1'b0, 1'b0, 32'h0, 32'h0, b, 0, '0);
            end
        end

        o = -1;
        for (int j = NCPU - 1; j >= 0; j--) if (hmask[j] && j != w) o = j;

        if (t == UPG) begin
            drive_cycle(rand_st(), w);
            dw = '1;
            dw[w] = 1'b0;
            observe("inv", dw, oth, oth, 1'b0, 1'b0, 32'h0, 32'h0, b, 0, '0);
        end else begin
            for (int k = 0; k < BLKWORDS; k++) begin
                lat = $urandom_range(1, 3);
                a   = b + 32'(4 * k);
                for (int i = 0; i < lat; i++) begin
                    acc = (i == lat - 1);
                    if (drop && k == 0 && i == 0) pend[w] = 1'b0;
                    drive_cycle(acc ? ACCESS : BUSY, w);
                    if (rst_word == k && i == 0) begin
                        nRST = 1'b0;
                        pend = '0;
                        req  = '0;
                        observe_idle("reset_mid");
                        #2 nRST = 1'b1;
                        last_m = NCPU - 1;
                        return;
                    end
                    dw = '1;
                    ci = '0;
                    dl = '0;
                    if (t == WBT) begin
                        dw[w] = !acc;
                        observe("wb", dw, '0, '0, 1'b0, 1'b1, a, dstore[w], 32'h0, k, '0);
                    end else if (o < 0) begin
                        dw[w] = !acc;
                        dl[w] = ramload;
                        if (t == RDX && k == 0 && i == 0) ci = oth;
                        observe("fill", dw, oth, ci, 1'b1, 1'b0, a, 32'h0, b, k, dl);
                    end else begin
                        dw[w] = !acc;
                        dw[o] = !acc;
                        dl[w] = dstore[o];
                        if (t == RDX && acc && k == BLKWORDS - 1) ci[o] = 1'b1;
                        observe("fwd", dw, oth, ci, 1'b0, 1'b1, a, dstore[o], b, k, dl);
                    end
                end
            end
        end

        pend[w] = 1'b0;
        drive_cycle(rand_st(), w);
        observe_idle("done");
    endtask

    initial begin
        nRST = 1'b0; pend = '0; req = '0; hitm = '0; reqtype = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE; last_m = NCPU - 1;
        observe_idle("reset");
        nRST = 1'b1;

        // two simultaneous reads, then again to see the pointer rotate back
        repeat (2) begin
            post_req(0, RD, 32'h1000);
            post_req(1, RD, 32'h1010);
            run_next('0, 1'b0, -1);
            run_next('0, 1'b0, -1);
        end
        post_req(2, RD, 32'h100);   run_next('0, 1'b0, -1);
        post_req(0, RDX, 32'h200);  run_next(4'b0010, 1'b0, -1);
        post_req(1, UPG, 32'h300);  run_next(4'b0001, 1'b0, -1);
        post_req(3, WBT, 32'h40);   run_next('0, 1'b0, -1);
        post_req(1, RDX, 32'h50C);  run_next(4'b1111, 1'b1, -1);
        post_req(2, RD, 32'h180);   run_next('0, 1'b0, 1);
        post_req(2, RD, 32'h700);
        post_req(0, RD, 32'h600);
        while (pend != '0) run_next('0, 1'b0, -1);

        for (int r = 0; r < 40; r++) begin
            logic [NCPU-1:0] m;
            m = NCPU'($urandom_range(1, (1 << NCPU) - 1));
            for (int c = 0; c < NCPU; c++)
                if (m[c]) post_req(c, int'($urandom_range(0, 3)), $urandom);
            while (pend != '0)
                run_next(($urandom_range(0, 1) == 1) ? NCPU'($urandom) : '0,
                         ($urandom_range(0, 3) == 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Parametrised snooping-bus coherence controller for an NCPU-core MSI system with BLKWORDS-word data-cache blocks. Sits between the per-core dcache controllers and the single-ported RAM, replacing the fixed two-core controller. Provides round-robin bus arbitration, snoop broadcast, cache-to-cache forwarding with simultaneous memory update, memory fill, writeback and upgrade invalidation.

## Interface
- NCPU, 2: number of cores; 2..8.
- BLKWORDS, 2: words per cache block; power of two, 1..8.
- SNPLAT, 2: cycles snoopers get to answer (ccwait held); ≥1.
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req  in  NCPU  per-core bus request; held until the transaction completes
- reqtype  in  NCPU×2  00 RD (read miss), 01 RDX (write miss), 10 UPG (S→M), 11 WB (evict M block)
- daddr  in  NCPU×32  requester block address (low log2(BLKWORDS)+2 bits ignored)
- dstore  in  NCPU×32  write/forward data word from each core
- hitm  in  NCPU  snooper holds snooped block in M; sampled on the last SNOOP cycle
- dwait  out  NCPU  per-core wait; low for one cycle per accepted or delivered word
- dload  out  NCPU×32  fill data to the requester
- wordsel  out  log2(BLKWORDS)  current word index in the block (to requester and supplier)
- ccwait  out  NCPU  snoop in progress for that core
- ccinv  out  NCPU  invalidate snooped block (S/M→I)
- ccsnoopaddr  out  32  block address being snooped (low bits zero)
- ramaddr  out  32;  ramstore  out  32;  ramREN, ramWEN  out  1 each
- ramload  in  32;  ramstate  in  ramstate_t; word completes on cycle ramstate==ACCESS

## Operation
- States: IDLE, SNOOP, FILL, FWD, WB, INV, DONE.
- Grant: in IDLE, winner = first requesting core after `last` (wrapping modulo NCPU); `last`←winner. Grant id, type, block address (low bits zeroed), word counter k=0 latched at grant; no input is resampled except per-word data.
- WB request: IDLE→WB, no snoop. Each cycle ramWEN=1, ramaddr=base+4k, ramstore=dstore[id]. On ACCESS: dwait[id]=0, k++. After word BLKWORDS-1 → DONE.
- RD/RDX/UPG: IDLE→SNOOP. ccsnoopaddr=base, ccwait[j]=1 for all j≠id for SNPLAT cycles. On last cycle sample hitm over j≠id.
- UPG → INV: ccinv[j]=1 for all j≠id for one cycle, dwait[id]=0 that cycle → DONE. hitm ignored.
- RD/RDX with no hitm → FILL: ramREN=1, ramaddr=base+4k, dload[id]=ramload; on ACCESS dwait[id]=0, k++; last word → DONE. For RDX, ccinv[j≠id]=1 on the first FILL cycle.
- RD/RDX with hitm from core o (lowest index if multiple; protocol error, lowest wins) → FWD: dload[id]=dstore[o]; ramWEN=1, ramaddr=base+4k, ramstore=dstore[o]; on ACCESS dwait[id]=dwait[o]=0, k++; last word → DONE. ccinv[o]=1 on final FWD cycle for RDX; for RD, supplier downgrades M→S itself.
- ccwait stays asserted to all non-requesters from SNOOP entry through FILL/FWD/INV exit.
- DONE: one cycle, all outputs idle; requester must drop req. → IDLE.
- Outputs default: dwait all 1, everything else 0.

## Timing
- Reset: state IDLE, last=NCPU-1 (core 0 wins first), k=0, all dwait=1, all other outputs 0.
- Arbitration latency: grant registered on req edge; SNOOP/WB begins next cycle.
- Minimum RD miss: 1 grant + SNPLAT + BLKWORDS×(RAM latency) + 1 DONE.
- UPG: 1 + SNPLAT + 1 + 1 cycles.
- ACCESS with ramREN/ramWEN low never advances k.
- k wraps only by leaving the data state; never exceeds BLKWORDS-1.
- Request dropped mid-transaction: ignored; transaction completes.
- Simultaneous requests: exactly one granted per IDLE; others wait with dwait=1.
- nRST low mid-transaction: immediate return to reset values; RAM access abandoned.

## Test plan
- Reset, then req[0]=req[1]=1 RD → core 0 granted first, core 1 next; `last` rotates 0→1→0.
- NCPU=4, BLKWORDS=4, core 2 RD 0x100, no hitm, RAM latency 2 → ramaddr 0x100,0x104,0x108,0x10C; four dwait[2] pulses; ccwait[0,1,3]=1 throughout.
- Core 0 RDX 0x200, hitm[1]=1 → dload[0]=dstore[1], ramWEN with same data, ccinv[1] on last word, ccinv[1] also never asserted to core 0.
- Core 1 UPG 0x300 → ccwait[0] for SNPLAT cycles, then ccinv[0] one cycle, dwait[1]=0 same cycle, no RAM access.
- Core 3 WB 0x40, BLKWORDS=2 → ramWEN at 0x40, 0x44 with dstore[3]; no ccwait asserted.
- nRST pulsed during FILL word 1 → all outputs at reset values same cycle; next req granted to core 0.
